// File: rtl/ws2812_serializer_pkg.sv
// Shared types and default timing for the WS2812 serializer and the LED controller register file.
package ws2812_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam int unsigned COLOR_W   = 24;
  localparam int unsigned CH_W      = 8;
  localparam int unsigned BIT_CNT_W = 5;

  // Field positions of a colour word, G in the MSBs so it is sent first.
  typedef struct packed {
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] b;
  } color_t;

  // Defaults for a 10 MHz clock.
  localparam int unsigned DEF_LED_CNT = 10;
  localparam int unsigned DEF_T0H     = 4;
  localparam int unsigned DEF_T1H     = 8;
  localparam int unsigned DEF_TBIT    = 13;
  localparam int unsigned DEF_TRESET  = 600;
  localparam int unsigned DEF_IDX_W   = 8;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// NRZ bit-period generator: one TBIT-cycle period per bit, high for T0H or T1H cycles.
module ws2812_bit_encoder
  import ws2812_serializer_pkg::*;
#(
  parameter int unsigned T0H  = DEF_T0H,
  parameter int unsigned T1H  = DEF_T1H,
  parameter int unsigned TBIT = DEF_TBIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic bit_i,
  output logic led_o,
  output logic bit_last_c_o
);

  localparam int unsigned CYC_W = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TBIT - 1);
  localparam logic [CYC_W-1:0] HI_0     = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] HI_1     = CYC_W'(T1H);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             led_q, led_d;

  // Counter restarts at 0 whenever the encoder is idle, so the first bit starts cleanly.
  always_comb begin
    cyc_d = '0;
    led_d = 1'b0;
    if (en_i) begin
      led_d = (cyc_q < (bit_i ? HI_1 : HI_0));
      cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      led_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      led_q <= led_d;
    end
  end

  assign led_o        = led_q;
  assign bit_last_c_o = en_i && (cyc_q == CYC_LAST);

endmodule

// File: rtl/ws2812_serializer.sv
// Frame sequencer: fetches colour words, streams them MSB first without gaps, then holds the latch time.
module ws2812_serializer
  import ws2812_serializer_pkg::*;
#(
  parameter int unsigned LED_CNT = DEF_LED_CNT,
  parameter int unsigned T0H     = DEF_T0H,
  parameter int unsigned T1H     = DEF_T1H,
  parameter int unsigned TBIT    = DEF_TBIT,
  parameter int unsigned TRESET  = DEF_TRESET,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic [IDX_W-1:0]   rd_idx_o,
  output logic               rd_en_o,
  input  logic [COLOR_W-1:0] rd_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               led_o
);

  localparam int unsigned LAT_W = $clog2(TRESET + 1);
  localparam logic [LAT_W-1:0]     LAT_END  = LAT_W'(TRESET - 1);
  localparam logic [LAT_W-1:0]     LAT_HOLD = LAT_W'(TRESET);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(LED_CNT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_TOP  = BIT_CNT_W'(COLOR_W - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic                 rd_en_q, rd_en_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [COLOR_W-1:0]   sr_q, sr_d;
  color_t               hold_q, hold_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [IDX_W-1:0]     led_idx_q, led_idx_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 bit_last_c;

  ws2812_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_enc (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (state_q == ST_SHIFT),
    .bit_i        (sr_q[COLOR_W-1]),
    .led_o        (led_o),
    .bit_last_c_o (bit_last_c)
  );

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_en_d   = 1'b0;
    rd_vld_d  = rd_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sr_d      = sr_q;
    hold_d    = hold_q;
    bit_d     = bit_q;
    led_idx_d = led_idx_q;
    lat_d     = lat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_FETCH;
          rd_idx_d  = '0;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
          led_idx_d = '0;
        end
      end

      ST_FETCH: begin
        if (rd_vld_q) begin
          sr_d    = rd_data_i;
          bit_d   = BIT_TOP;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Prefetched word lands one cycle after the strobe, well before the bit-0 boundary.
        if (rd_vld_q) begin
          hold_d = color_t'(rd_data_i);
        end
        if (bit_last_c) begin
          if (bit_q == '0) begin
            sr_d  = hold_q;
            bit_d = BIT_TOP;
            if (led_idx_q == LAST_IDX) begin
              state_d = ST_LATCH;
              lat_d   = '0;
            end else begin
              led_idx_d = led_idx_q + IDX_W'(1);
            end
          end else begin
            sr_d  = sr_q << 1;
            bit_d = bit_q - BIT_CNT_W'(1);
            // Entering bit 0: request the next LED's word during its first cycle.
            if ((bit_q == BIT_CNT_W'(1)) && (led_idx_q != LAST_IDX)) begin
              rd_en_d  = 1'b1;
              rd_idx_d = led_idx_q + IDX_W'(1);
            end
          end
        end
      end

      ST_LATCH: begin
        // One extra LATCH cycle carries done_o so a start in that cycle is ignored.
        if (lat_q == LAT_END) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          lat_d  = LAT_HOLD;
        end else if (lat_q == LAT_HOLD) begin
          state_d = ST_IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_idx_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sr_q      <= '0;
      hold_q    <= '0;
      bit_q     <= '0;
      led_idx_q <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      rd_en_q   <= rd_en_d;
      rd_vld_q  <= rd_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sr_q      <= sr_d;
      hold_q    <= hold_d;
      bit_q     <= bit_d;
      led_idx_q <= led_idx_d;
      lat_q     <= lat_d;
    end
  end

  assign rd_idx_o = rd_idx_q;
  assign rd_en_o  = rd_en_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Randomised frame bench for ws2812_serializer with a cycle-offset reference model and a pulse-width decoder.
`timescale 1ns/1ps
module tb_ws2812_serializer;

  localparam int LED_CNT = 3;
  localparam int T0H     = 4;
  localparam int T1H     = 8;
  localparam int TBIT    = 13;
  localparam int TRESET  = 600;
  localparam int IDX_W   = 8;
  localparam int FRAME_B = 2 + LED_CNT * 24 * TBIT + TRESET;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [IDX_W-1:0] rd_idx_o;
  logic             rd_en_o;
  logic [23:0]      rd_data_i = 24'h0;
  logic             busy_o;
  logic             done_o;
  logic             led_o;

  logic [23:0] mem [LED_CNT];
  int n_chk = 0;
  int n_pass = 0;

  ws2812_serializer #(
    .LED_CNT (LED_CNT),
    .T0H     (T0H),
    .T1H     (T1H),
    .TBIT    (TBIT),
    .TRESET  (TRESET),
    .IDX_W   (IDX_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .rd_idx_o  (rd_idx_o),
    .rd_en_o   (rd_en_o),
    .rd_data_i (rd_data_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .led_o     (led_o)
  );

  always #5 clk = ~clk;

  // Colour register file: synchronous read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= (int'(rd_idx_o) < LED_CNT) ? mem[int'(rd_idx_o)] : 24'hDEAD00;
  end

  task automatic check(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Expected line level k edges after the start-sampling edge.
  function automatic logic f_led(input int kk);
    int t, j, c, n, b;
    logic bv;
    if (kk < 3) return 1'b0;
    t = kk - 3;
    j = t / TBIT;
    c = t % TBIT;
    if (j >= LED_CNT * 24) return 1'b0;
    n = j / 24;
    b = 23 - (j % 24);
    bv = mem[n][b];
    return (c < (bv ? T1H : T0H));
  endfunction

  function automatic logic f_en(input int kk);
    int j;
    if (kk == 0) return 1'b1;
    if (kk < 2 || ((kk - 2) % TBIT) != 0) return 1'b0;
    j = (kk - 2) / TBIT;
    return ((j % 24) == 23) && ((j / 24) < LED_CNT - 1);
  endfunction

  // Frame position tracker: k counts edges since start acceptance; k==FRAME_B is the done cycle.
  bit act;
  int k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 1'b0;
      k   <= 0;
    end else if (act) begin
      if (k == FRAME_B) act <= 1'b0;
      else k <= k + 1;
    end else if (start_i) begin
      act <= 1'b1;
      k   <= 0;
    end
  end

  int          exp_idx = 0;
  int          hw = 0;
  int          dec_n = 0;
  logic [23:0] dec_w [LED_CNT];

  always @(negedge clk) begin
    logic e_led, e_busy, e_done, e_en;
    e_led = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0;
    if (!rst_n) begin
      exp_idx = 0;
      hw = 0;
      dec_n = 0;
    end else begin
      if (act) begin
        e_busy = (k < FRAME_B);
        e_done = (k == FRAME_B);
        e_led  = f_led(k);
        e_en   = f_en(k);
        if (e_en) exp_idx = (k == 0) ? 0 : ((k - 2) / TBIT) / 24 + 1;
        if (k == 0) begin
          hw = 0;
          dec_n = 0;
        end
      end
      // Independent decode of the line by high time.
      if (led_o) hw++;
      else if (hw > 0) begin
        check("pulse_width_valid", ((hw == T0H) || (hw == T1H)) ? 1 : 0, 1);
        if (dec_n < LED_CNT * 24) dec_w[dec_n / 24][23 - (dec_n % 24)] = (hw == T1H);
        dec_n++;
        hw = 0;
      end
      if (act && k == FRAME_B) begin
        check("decoded_bit_count", dec_n, LED_CNT * 24);
        for (int n = 0; n < LED_CNT; n++) check("decoded_word", dec_w[n], mem[n]);
      end
    end
    check("led_o", led_o, e_led);
    check("busy_o", busy_o, e_busy);
    check("done_o", done_o, e_done);
    check("rd_en_o", rd_en_o, e_en);
    check("rd_idx_o", rd_idx_o, exp_idx);
  end

  task automatic run_frame(input bit poke_mid, input bit poke_done,
                           output int blen, output int frise, output int fhi,
                           output int ndone, output int quiet);
    int cnt;
    bit fin, closed;
    blen = 0; frise = -1; fhi = 0; ndone = 0; quiet = 0;
    cnt = 0; fin = 1'b0; closed = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    while (!fin && cnt < FRAME_B + 50) begin
      @(negedge clk);
      start_i = (poke_mid && cnt == 500) ? 1'b1 : 1'b0;
      if (busy_o) blen++;
      if (led_o && frise < 0) frise = cnt;
      if (frise >= 0 && !closed) begin
        if (led_o) fhi++;
        else closed = 1'b1;
      end
      if (done_o) begin
        ndone++;
        fin = 1'b1;
        if (poke_done) start_i = 1'b1;
      end
      cnt++;
    end
    if (!fin) check("done_timeout", 0, 1);
    @(negedge clk);
    start_i = 1'b0;
    if (busy_o || done_o) quiet++;
    repeat (20) begin
      @(negedge clk);
      if (busy_o || done_o) quiet++;
      if (done_o) ndone++;
    end
  endtask

  initial begin
    int bl, fr, fh, dn, qt, noisy;
    noisy = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (100) begin
      @(negedge clk);
      if (busy_o || led_o || rd_en_o || done_o) noisy++;
    end
    check("idle_quiet", noisy, 0);

    mem[0] = 24'hFF0000;
    mem[1] = 24'h000001;
    mem[2] = 24'h80A5C3;
    run_frame(1'b0, 1'b0, bl, fr, fh, dn, qt);
    check("busy_len", bl, 1538);
    check("first_rise", fr, 3);
    check("first_high_w", fh, 8);
    check("done_count", dn, 1);

    for (int n = 0; n < LED_CNT; n++) mem[n] = 24'($urandom);
    mem[0][23] = 1'b0;
    run_frame(1'b1, 1'b1, bl, fr, fh, dn, qt);
    check("busy_len_poked", bl, FRAME_B);
    check("first_high_w_0", fh, 4);
    check("done_count_poked", dn, 1);
    check("no_requeue", qt, 0);

    for (int n = 0; n < LED_CNT; n++) mem[n] = 24'($urandom);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (550) @(negedge clk);
    check("pre_reset_led", led_o, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", led_o, 0);
    check("async_busy", busy_o, 0);
    check("async_rd_en", rd_en_o, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    run_frame(1'b0, 1'b0, bl, fr, fh, dn, qt);
    check("busy_len_after_reset", bl, FRAME_B);
    check("first_rise_after_reset", fr, 3);

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < LED_CNT; n++) mem[n] = 24'($urandom);
      run_frame(1'b0, 1'b0, bl, fr, fh, dn, qt);
      check("busy_len_rand", bl, FRAME_B);
      check("done_count_rand", dn, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
